// File: rtl/json_scan_ctrl_if.sv
// Byte-stream, structural-event and status bundle of the JSON structural scanner.
// The master side feeds bytes and consumes events; the slave side is the scanner itself.
interface json_scan_ctrl_if #(
  parameter int MAX_DEPTH = 32,
  parameter int POS_W     = 32
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             ev_valid;
  logic             ev_ready;
  logic [2:0]       ev_kind;
  logic [DW-1:0]    ev_depth;
  logic [POS_W-1:0] ev_pos;
  logic             err_valid;
  logic [2:0]       err_kind;
  logic [POS_W-1:0] err_pos;
  logic             done;
  logic [DW-1:0]    depth;

  modport master (
    output in_valid, in_data, in_last, ev_ready,
    input  in_ready, ev_valid, ev_kind, ev_depth, ev_pos,
    input  err_valid, err_kind, err_pos, done, depth
  );

  modport slave (
    input  in_valid, in_data, in_last, ev_ready,
    output in_ready, ev_valid, ev_kind, ev_depth, ev_pos,
    output err_valid, err_kind, err_pos, done, depth
  );
endinterface

// File: rtl/json_scan_ctrl.sv
// Streaming JSON structural scanner: tracks string/escape/nesting state one byte per cycle
// and emits one registered structural event per significant byte, or a sticky error.
module json_scan_ctrl #(
  parameter int MAX_DEPTH = 32,
  parameter int POS_W     = 32
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clear,
  json_scan_ctrl_if.slave bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);

  localparam logic [2:0] EV_OBJ_OPEN  = 3'd0;
  localparam logic [2:0] EV_OBJ_CLOSE = 3'd1;
  localparam logic [2:0] EV_ARR_OPEN  = 3'd2;
  localparam logic [2:0] EV_ARR_CLOSE = 3'd3;
  localparam logic [2:0] EV_STR_START = 3'd4;
  localparam logic [2:0] EV_STR_END   = 3'd5;
  localparam logic [2:0] EV_COLON     = 3'd6;
  localparam logic [2:0] EV_COMMA     = 3'd7;

  localparam logic [2:0] ERR_CLOSE_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW      = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW       = 3'd3;
  localparam logic [2:0] ERR_BAD_ESCAPE     = 3'd4;
  localparam logic [2:0] ERR_UNTERMINATED   = 3'd5;

  typedef enum logic [2:0] {RUN, STR, ESC, DONE, ERR} state_t;

  state_t           r_state;
  logic [MAX_DEPTH-1:0] r_stack;
  logic [DW-1:0]    r_depth;
  logic [POS_W-1:0] r_pos;
  logic             r_evValid;
  logic [2:0]       r_evKind;
  logic [DW-1:0]    r_evDepth;
  logic [POS_W-1:0] r_evPos;
  logic             r_errValid;
  logic [2:0]       r_errKind;
  logic [POS_W-1:0] r_errPos;
  logic             r_done;

  logic             w_inReady;
  logic             w_accept;
  logic             w_top;
  logic             w_isObj;
  logic             w_evFire;
  logic [2:0]       w_evKind;
  logic             w_byteErr;
  logic             w_errFire;
  logic [2:0]       w_errKind;
  logic             w_push;
  logic [DW-1:0]    w_depthN;
  state_t           w_stateN;

  assign w_inReady = ((r_state == RUN) || (r_state == STR) || (r_state == ESC)) &&
                     (!r_evValid || bus.ev_ready) && !clear;
  assign w_accept  = bus.in_valid && w_inReady;
  assign w_isObj   = (bus.in_data == 8'h7B) || (bus.in_data == 8'h7D);

  // Stack entry just below the current depth holds the type of the innermost open container.
  always_comb begin
    w_top = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DW'(i + 1) == r_depth) w_top = r_stack[i];
    end
  end

  always_comb begin
    w_evFire  = 1'b0;
    w_evKind  = EV_OBJ_OPEN;
    w_byteErr = 1'b0;
    w_errFire = 1'b0;
    w_errKind = 3'd0;
    w_push    = 1'b0;
    w_depthN  = r_depth;
    w_stateN  = r_state;
    case (r_state)
      RUN: begin
        case (bus.in_data)
          8'h7B, 8'h5B: begin
            if (r_depth == MAXD) begin
              w_byteErr = 1'b1;
              w_errKind = ERR_OVERFLOW;
            end else begin
              w_push   = 1'b1;
              w_depthN = r_depth + 1'b1;
              w_evFire = 1'b1;
              w_evKind = w_isObj ? EV_OBJ_OPEN : EV_ARR_OPEN;
            end
          end
          8'h7D, 8'h5D: begin
            if (r_depth == '0) begin
              w_byteErr = 1'b1;
              w_errKind = ERR_UNDERFLOW;
            end else if (w_top != w_isObj) begin
              w_byteErr = 1'b1;
              w_errKind = ERR_CLOSE_MISMATCH;
            end else begin
              w_depthN = r_depth - 1'b1;
              w_evFire = 1'b1;
              w_evKind = w_isObj ? EV_OBJ_CLOSE : EV_ARR_CLOSE;
            end
          end
          8'h22: begin
            w_evFire = 1'b1;
            w_evKind = EV_STR_START;
            w_stateN = STR;
          end
          8'h3A: begin
            w_evFire = 1'b1;
            w_evKind = EV_COLON;
          end
          8'h2C: begin
            w_evFire = 1'b1;
            w_evKind = EV_COMMA;
          end
          default: ;
        endcase
      end
      STR: begin
        if (bus.in_data == 8'h22) begin
          w_evFire = 1'b1;
          w_evKind = EV_STR_END;
          w_stateN = RUN;
        end else if (bus.in_data == 8'h5C) begin
          w_stateN = ESC;
        end
      end
      ESC: begin
        case (bus.in_data)
          8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66, 8'h6E, 8'h72, 8'h74, 8'h75: w_stateN = STR;
          default: begin
            w_byteErr = 1'b1;
            w_errKind = ERR_BAD_ESCAPE;
          end
        endcase
      end
      default: ;
    endcase

    // A byte error wins over the end-of-document check for the same byte.
    if (w_byteErr) begin
      w_errFire = 1'b1;
      w_stateN  = ERR;
    end else if (bus.in_last) begin
      if ((w_stateN == RUN) && (w_depthN == '0)) begin
        w_stateN = DONE;
      end else begin
        w_errFire = 1'b1;
        w_errKind = ERR_UNTERMINATED;
        w_stateN  = ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_stack    <= '0;
      r_depth    <= '0;
      r_pos      <= '0;
      r_evValid  <= 1'b0;
      r_evKind   <= 3'd0;
      r_evDepth  <= '0;
      r_evPos    <= '0;
      r_errValid <= 1'b0;
      r_errKind  <= 3'd0;
      r_errPos   <= '0;
      r_done     <= 1'b0;
    end else if (clear) begin
      r_state    <= RUN;
      r_depth    <= '0;
      r_pos      <= '0;
      r_evValid  <= 1'b0;
      r_evKind   <= 3'd0;
      r_evDepth  <= '0;
      r_evPos    <= '0;
      r_errValid <= 1'b0;
      r_errKind  <= 3'd0;
      r_errPos   <= '0;
      r_done     <= 1'b0;
    end else begin
      if (r_evValid && bus.ev_ready) r_evValid <= 1'b0;
      if (w_accept) begin
        r_pos   <= r_pos + 1'b1;
        r_state <= w_stateN;
        r_depth <= w_depthN;
        if (w_push) begin
          for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DW'(i) == r_depth) r_stack[i] <= w_isObj;
          end
        end
        if (w_evFire) begin
          r_evValid <= 1'b1;
          r_evKind  <= w_evKind;
          r_evDepth <= w_depthN;
          r_evPos   <= r_pos;
        end
        if (w_errFire) begin
          r_errValid <= 1'b1;
          r_errKind  <= w_errKind;
          r_errPos   <= r_pos;
        end
        if (w_stateN == DONE) r_done <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.ev_valid  = r_evValid;
  assign bus.ev_kind   = r_evKind;
  assign bus.ev_depth  = r_evDepth;
  assign bus.ev_pos    = r_evPos;
  assign bus.err_valid = r_errValid;
  assign bus.err_kind  = r_errKind;
  assign bus.err_pos   = r_errPos;
  assign bus.done      = r_done;
  assign bus.depth     = r_depth;
endmodule
